// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: default geometry, lane-valid and pop
// encodings, and the helpers that turn them into entry counts.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH    = 16;
  localparam int unsigned FQ_INST_W   = 32;
  localparam int unsigned FQ_ADDR_W   = 32;
  localparam int unsigned FQ_AFULL_TH = 4;

  typedef enum logic [1:0] {
    VLD_NONE  = 2'b00,
    VLD_LANE0 = 2'b01,
    VLD_LANE1 = 2'b10,
    VLD_BOTH  = 2'b11
  } lane_vld_e;

  typedef enum logic [1:0] {
    POP_NONE      = 2'd0,
    POP_ONE       = 2'd1,
    POP_TWO       = 2'd2,
    POP_TWO_ALIAS = 2'd3
  } pop_e;

  // Lane1 without lane0 is not a legal fetch group and counts as nothing.
  function automatic logic [1:0] push_count(logic [1:0] vld);
    logic [1:0] n;
    case (vld)
      VLD_BOTH:  n = 2'd2;
      VLD_LANE0: n = 2'd1;
      default:   n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] clamp_pop(logic [1:0] req, logic has1, logic has2);
    logic [1:0] want;
    want = (req == POP_TWO_ALIAS) ? 2'd2 : req;
    if (!has1)
      return 2'd0;
    if (!has2 && want == 2'd2)
      return 2'd1;
    return want;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side push lanes and decode-side pop lanes of the fetch queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned INST_W = FQ_INST_W,
  parameter int unsigned ADDR_W = FQ_ADDR_W,
  parameter int unsigned DEPTH  = FQ_DEPTH
);

  logic [1:0]            in_valid;
  logic [2*INST_W-1:0]   in_inst;
  logic [2*ADDR_W-1:0]   in_pc;
  logic [1:0]            in_pred;
  logic                  in_ready;
  logic                  almost_full;
  logic [1:0]            out_valid;
  logic [2*INST_W-1:0]   out_inst;
  logic [2*ADDR_W-1:0]   out_pc;
  logic [1:0]            out_pred;
  logic [1:0]            pop_num;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output in_valid, in_inst, in_pc, in_pred, pop_num,
    input  in_ready, almost_full, out_valid, out_inst, out_pc, out_pred, count
  );

  modport slave (
    input  in_valid, in_inst, in_pc, in_pred, pop_num,
    output in_ready, almost_full, out_valid, out_inst, out_pc, out_pred, count
  );

endinterface

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: two write ports, two asynchronous read
// ports, separate arrays for instruction, PC and prediction bit.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned INST_W = FQ_INST_W,
  parameter int unsigned ADDR_W = FQ_ADDR_W
) (
  input  logic                     clk,
  input  logic                     we0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr0_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  logic [INST_W-1:0]        winst0_i,
  input  logic [INST_W-1:0]        winst1_i,
  input  logic [ADDR_W-1:0]        wpc0_i,
  input  logic [ADDR_W-1:0]        wpc1_i,
  input  logic                     wpred0_i,
  input  logic                     wpred1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr0_i,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output logic [INST_W-1:0]        rinst0_o,
  output logic [INST_W-1:0]        rinst1_o,
  output logic [ADDR_W-1:0]        rpc0_o,
  output logic [ADDR_W-1:0]        rpc1_o,
  output logic                     rpred0_o,
  output logic                     rpred1_o
);

  logic [INST_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic              pred_q [DEPTH];

  // Contents are deliberately unreset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (we0_i) begin
      inst_q[waddr0_i] <= winst0_i;
      pc_q[waddr0_i]   <= wpc0_i;
      pred_q[waddr0_i] <= wpred0_i;
    end
    if (we1_i) begin
      inst_q[waddr1_i] <= winst1_i;
      pc_q[waddr1_i]   <= wpc1_i;
      pred_q[waddr1_i] <= wpred1_i;
    end
  end

  assign rinst0_o = inst_q[raddr0_i];
  assign rinst1_o = inst_q[raddr1_i];
  assign rpc0_o   = pc_q[raddr0_i];
  assign rpc1_o   = pc_q[raddr1_i];
  assign rpred0_o = pred_q[raddr0_i];
  assign rpred1_o = pred_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// Dual-lane first-word-fall-through fetch queue between fetch and decode.
// Holds head/tail/count and the handshake; entries live in fq_storage.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = FQ_DEPTH,
  parameter int unsigned INST_W   = FQ_INST_W,
  parameter int unsigned ADDR_W   = FQ_ADDR_W,
  parameter int unsigned AFULL_TH = FQ_AFULL_TH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          clear,
  fetch_queue_if.slave  q
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] head_nxt1, tail_nxt1;
  logic [CW-1:0] count_q, count_d, free_w;
  logic [1:0]    npush, npop;
  logic          ready_w, push_ok, we0, we1;

  assign free_w  = CW'(DEPTH) - count_q;
  assign ready_w = (free_w >= CW'(2));

  // Pushes need two free slots before any same-cycle pop, so writes never
  // land on an entry that is still live.
  assign push_ok = rdy && !clear && ready_w && (push_count(q.in_valid) != 2'd0);
  assign npush   = push_ok ? push_count(q.in_valid) : 2'd0;
  assign npop    = (rdy && !clear) ?
                   clamp_pop(q.pop_num, count_q != '0, count_q >= CW'(2)) : 2'd0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy) begin
      if (clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        head_d  = head_q + PW'(npop);
        tail_d  = tail_q + PW'(npush);
        count_d = count_q + CW'(npush) - CW'(npop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign we0       = rst_n && (npush != 2'd0);
  assign we1       = rst_n && (npush == 2'd2);
  assign tail_nxt1 = tail_q + PW'(1);
  assign head_nxt1 = head_q + PW'(1);

  fq_storage #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W),
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk      (clk),
    .we0_i    (we0),
    .we1_i    (we1),
    .waddr0_i (tail_q),
    .waddr1_i (tail_nxt1),
    .winst0_i (q.in_inst[0 +: INST_W]),
    .winst1_i (q.in_inst[INST_W +: INST_W]),
    .wpc0_i   (q.in_pc[0 +: ADDR_W]),
    .wpc1_i   (q.in_pc[ADDR_W +: ADDR_W]),
    .wpred0_i (q.in_pred[0]),
    .wpred1_i (q.in_pred[1]),
    .raddr0_i (head_q),
    .raddr1_i (head_nxt1),
    .rinst0_o (q.out_inst[0 +: INST_W]),
    .rinst1_o (q.out_inst[INST_W +: INST_W]),
    .rpc0_o   (q.out_pc[0 +: ADDR_W]),
    .rpc1_o   (q.out_pc[ADDR_W +: ADDR_W]),
    .rpred0_o (q.out_pred[0]),
    .rpred1_o (q.out_pred[1])
  );

  assign q.in_ready    = ready_w;
  assign q.almost_full = (free_w < CW'(AFULL_TH));
  assign q.out_valid   = {count_q >= CW'(2), count_q != '0};
  assign q.count       = count_q;

endmodule
